reciprocal_unit: RTL and testbench

- Sequential fixed-point reciprocal engine for the ray tracer: computes 1/x for a signed Qm.n operand, used for per-axis DDA step distances and wall-height scaling.
- Radix-2 restoring long division of 2^(2*QF) by |x|, one quotient bit per clock, with saturation detection.
- Sits between tracer state-machine registers (ray direction, wall distance) and the DDA/height logic.

---
 rtl/reciprocal_unit.sv | 88 ++++++++
 tb/tb_reciprocal_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reciprocal_unit.sv
// reciprocal_unit: sequential signed QI.QF reciprocal by restoring division of 2^(2*QF) by |x|, with saturation.
// Define RECIP_ROUND_EN for a round-half-up quotient (one extra iteration, one extra cycle of latency).
module reciprocal_unit #(
  parameter int QI = 12,
  parameter int QF = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [QI+QF-1:0]   i_data,
  input  logic               i_abs,
  output logic [QI+QF-1:0]   o_data,
  output logic               o_sat,
  output logic               o_valid,
  output logic               o_busy
);
  localparam int W = QI + QF;
`ifdef RECIP_ROUND_EN
  localparam int NQ = 2 * QF + 2;
`else
  localparam int NQ = 2 * QF + 1;
`endif
  localparam int CW = (NQ > W) ? NQ : W;
  localparam int CNTW = $clog2(NQ + 1);
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t            r_state, w_next;
  logic [W-1:0]      r_m, r_rem, w_mag;
  logic              r_s, r_abs, w_ge, w_sat;
  logic [NQ-1:0]     r_q, w_q;
  logic [CNTW-1:0]   r_cnt;
  logic [W:0]        w_sh;
  always_comb begin
    w_next = (r_state == IDLE) ? (i_start ? DIV : IDLE) :
             (r_state == DIV)  ? ((r_cnt == CNTW'(NQ)) ? DONE : DIV) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  assign o_busy = r_state != IDLE;
  // The dividend is a single 1 followed by zeros, so only the first iteration shifts in a 1.
  assign w_sh = {r_rem, r_cnt == CNTW'(1)};
  assign w_ge = (r_m != '0) && (w_sh >= {1'b0, r_m});
`ifdef RECIP_ROUND_EN
  assign w_q = {1'b0, r_q[NQ-1:1]} + NQ'(r_q[0]);
`else
  assign w_q = r_q;
`endif
  assign w_sat = (r_m == '0) || (CW'(w_q) > CW'(MAXP));
  assign w_mag = w_sat ? MAXP : W'(w_q);
  // DIV cycle with r_cnt==0 only loads; quotient bits are produced while r_cnt runs 1..NQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m     <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_s     <= 1'b0;
      r_abs   <= 1'b0;
      o_data  <= '0;
      o_sat   <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (r_state == IDLE && i_start) begin
        r_m   <= i_data[W-1] ? -i_data : i_data;
        r_s   <= i_data[W-1];
        r_abs <= i_abs;
        r_cnt <= '0;
        r_rem <= '0;
        r_q   <= '0;
      end
      if (r_state == DIV) begin
        r_cnt <= r_cnt + CNTW'(1);
        if (r_cnt != '0) begin
          r_rem <= w_ge ? W'(w_sh - {1'b0, r_m}) : W'(w_sh);
          r_q   <= {r_q[NQ-2:0], w_ge || (r_m == '0)};
        end
      end
      if (r_state == DONE) begin
        o_data  <= (r_abs || !r_s) ? w_mag : -w_mag;
        o_sat   <= w_sat;
        o_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_reciprocal_unit.sv
// tb_reciprocal_unit: scoreboard bench for reciprocal_unit (honours RECIP_ROUND_EN).
module tb_reciprocal_unit;
  localparam int QI = 12;
  localparam int QF = 12;
  localparam int W = QI + QF;
`ifdef RECIP_ROUND_EN
  localparam int LAT = 2 * QF + 4;
  localparam logic [W-1:0] EXP6 = 24'h2AAAAB;
`else
  localparam int LAT = 2 * QF + 3;
  localparam logic [W-1:0] EXP6 = 24'h2AAAAA;
`endif
  logic clk = 1'b0, reset = 1'b1, i_start = 1'b0, i_abs = 1'b0;
  logic [W-1:0] i_data = '0;
  logic [W-1:0] o_data;
  logic o_sat, o_valid, o_busy;
  typedef struct packed {logic [W-1:0] d; logic s;} exp_t;
  exp_t sb[$];
  exp_t m_e;
  int errors = 0, checks = 0, n_valid = 0;

  reciprocal_unit #(.QI(QI), .QF(QF)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_data(i_data), .i_abs(i_abs),
    .o_data(o_data), .o_sat(o_sat), .o_valid(o_valid), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (o_valid) begin
      n_valid++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got data=%h sat=%b, required no result", o_data, o_sat);
      end else begin
        m_e = sb.pop_front();
        if ({o_data, o_sat} !== m_e) begin
          errors++;
          $display("FAIL result: got data=%h sat=%b, required data=%h sat=%b", o_data, o_sat, m_e.d, m_e.s);
        end
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] x, input logic a);
    longint m, q, q2;
    logic sat;
    logic [W-1:0] mag;
    m = x[W-1] ? (longint'(1) << W) - longint'(x) : longint'(x);
    if (m == 0) begin
      sat = 1'b1;
      q = 0;
    end else begin
`ifdef RECIP_ROUND_EN
      q2 = (longint'(1) << (2 * QF + 1)) / m;
      q = q2 / 2 + q2 % 2;
`else
      q2 = 0;
      q = (longint'(1) << (2 * QF)) / m;
`endif
      sat = q > ((longint'(1) << (W - 1)) - 1);
    end
    mag = sat ? {1'b0, {(W-1){1'b1}}} : q[W-1:0];
    model.d = (a || !x[W-1]) ? mag : -mag;
    model.s = sat;
  endfunction

  task automatic start(input logic [W-1:0] d, input logic a);
    @(negedge clk);
    i_start = 1'b1;
    i_data = d;
    i_abs = a;
    @(negedge clk);
    i_start = 1'b0;
    i_data = W'($urandom);
    i_abs = 1'($urandom);
  endtask

  task automatic go(input logic [W-1:0] d, input logic a, input logic [W-1:0] ed, input logic es);
    sb.push_back({ed, es});
    start(d, a);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk) #1;
      if (!o_busy && sb.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_done: got busy=%b pending=%0d after 100 cycles, required idle with 0 pending", o_busy, sb.size());
    sb.delete();
  endtask

  task automatic test_reset();
    int nv;
    #1;
    checks++;
    if ({o_data, o_sat, o_valid, o_busy} !== '0) begin
      errors++;
      $display("FAIL reset_state: got data=%h sat=%b valid=%b busy=%b, required all 0", o_data, o_sat, o_valid, o_busy);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    start(24'h001000, 1'b1);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({o_busy, o_valid, o_data, o_sat} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b valid=%b data=%h sat=%b, required all 0", o_busy, o_valid, o_data, o_sat);
    end
    @(negedge clk);
    reset = 1'b0;
    nv = n_valid;
    repeat (40) @(negedge clk);
    checks++;
    if (n_valid !== nv) begin
      errors++;
      $display("FAIL aborted_no_result: got %0d results, required 0", n_valid - nv);
    end
    go(24'h001000, 1'b1, 24'h001000, 1'b0);
    wait_done();
  endtask

  task automatic test_latency();
    int n;
    bit busy_drop;
    n = 0;
    busy_drop = 0;
    sb.push_back({24'h001000, 1'b0});
    @(negedge clk);
    i_start = 1'b1;
    i_data = 24'h001000;
    i_abs = 1'b1;
    @(posedge clk) #1;
    i_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk) #1;
      n++;
      if (o_valid) break;
      if (!o_busy) busy_drop = 1;
    end
    checks++;
    if (n !== LAT) begin
      errors++;
      $display("FAIL latency: got %0d edges, required %0d", n, LAT);
    end
    checks++;
    if (busy_drop || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_profile: got drop=%b busy_at_valid=%b, required drop=0 busy_at_valid=0", busy_drop, o_busy);
    end
    wait_done();
  endtask

  task automatic test_values();
    logic [W-1:0] td[11];
    logic         ta[11];
    logic [W-1:0] te[11];
    logic         ts[11];
    td = '{24'h002000, 24'h000800, 24'hFFC000, 24'hFFC000, 24'h000000, 24'h000002,
           24'h000003, 24'hFFFFFF, 24'h000006, 24'h003000, 24'h800000};
    ta = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    te = '{24'h000800, 24'h002000, 24'hFFFC00, 24'h000400, 24'h7FFFFF, 24'h7FFFFF,
           24'h555555, 24'h800001, EXP6, 24'h000555, 24'hFFFFFE};
    ts = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      go(td[i], ta[i], te[i], ts[i]);
      wait_done();
    end
  endtask

  task automatic test_busy_ignore();
    int nv;
    nv = n_valid;
    go(24'h002000, 1'b1, 24'h000800, 1'b0);
    repeat (5) @(negedge clk);
    i_start = 1'b1;
    i_data = 24'h000003;
    @(negedge clk);
    i_start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    checks++;
    if (n_valid - nv !== 1) begin
      errors++;
      $display("FAIL busy_ignore: got %0d results, required 1", n_valid - nv);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    seen = 0;
    go(24'h000800, 1'b1, 24'h002000, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk) #1;
      if (o_valid) begin
        seen = 1;
        break;
      end
    end
    sb.push_back({24'hFFF800, 1'b0});
    i_start = 1'b1;
    i_data = 24'hFFE000;
    i_abs = 1'b0;
    @(posedge clk) #1;
    i_start = 1'b0;
    checks++;
    if (!seen || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_accept: got seen=%b busy=%b, required seen=1 busy=1", seen, o_busy);
    end
    wait_done();
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    logic a;
    for (int i = 0; i < 12; i++) begin
      d = (i % 4 == 0) ? W'($urandom_range(0, 64)) : W'($urandom);
      a = 1'($urandom);
      m_e = model(d, a);
      go(d, a, m_e.d, m_e.s);
      wait_done();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_values();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
